// File: rtl/sccb_arbiter_pkg.sv
// Shared SCCB command/response encodings, arbiter state type and index-width helper.
package sccb_arbiter_pkg;

  localparam int SCCB_ADDR_W = 15;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_ERR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Requester index width for the supported range of 2..4 requesters.
  function automatic int idx_width(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/sccb_arbiter_if.sv
// Command/response port between the arbiter (master side) and the downstream SCCB master engine (slave side).
interface sccb_arbiter_if;
  import sccb_arbiter_pkg::*;

  logic [2:0]             mcmd;
  logic [SCCB_ADDR_W-1:0] maddr;
  logic [7:0]             mdata;
  logic                   scmdaccept;
  logic [1:0]             sresp;
  logic [7:0]             sdata;

  modport master (output mcmd, maddr, mdata, input scmdaccept, sresp, sdata);
  modport slave  (input mcmd, maddr, mdata, output scmdaccept, sresp, sdata);

endinterface

// File: rtl/sccb_rr_pick.sv
// Combinational round-robin picker: first pending requester at or after rr_ptr, ascending with wrap.
module sccb_rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             any_valid
);

  int slot;

  // NOTE: every output gets a default before the search so no path leaves a latch behind.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    any_valid  = 1'b0;
    slot       = 0;
    for (int k = 0; k < NREQ; k++) begin
      slot = int'(rr_ptr) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (i == slot && pending[i] && !any_valid) begin
          any_valid     = 1'b1;
          win_onehot[i] = 1'b1;
          win_idx       = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB master command port between NREQ requesters.
// Optional watchdog abort enabled by defining SCCB_ARB_TIMEOUT_EN.
module sccb_arbiter
  import sccb_arbiter_pkg::*;
#(
  parameter int          NREQ        = 2,
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic                        config_clk,
  input  logic                        config_reset_n,
  input  logic [3*NREQ-1:0]           req_mcmd,
  input  logic [SCCB_ADDR_W*NREQ-1:0] req_maddr,
  input  logic [8*NREQ-1:0]           req_mdata,
  output logic [NREQ-1:0]             req_scmdaccept,
  output logic [2*NREQ-1:0]           req_sresp,
  output logic [7:0]                  req_sdata,
  sccb_arbiter_if.master              sccb,
  output logic [NREQ-1:0]             grant,
  output logic                        busy
);

  localparam int IDX_W = idx_width(NREQ);

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr, grant_idx, win_idx, next_ptr;
  logic [NREQ-1:0]        pending, win_onehot;
  logic                   any_valid, complete, abort;
  logic [2:0]             mcmd_q, sel_cmd;
  logic [SCCB_ADDR_W-1:0] maddr_q, sel_addr;
  logic [7:0]             mdata_q, sel_data, sdata_q;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NREQ; i++) pending[i] = (req_mcmd[3*i +: 3] != MCMD_IDLE);
  end

  sccb_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .pending    (pending),
    .rr_ptr     (rr_ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .any_valid  (any_valid)
  );

  always_comb begin
    sel_cmd  = MCMD_IDLE;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_onehot[i]) begin
        sel_cmd  = req_mcmd[3*i +: 3];
        sel_addr = req_maddr[SCCB_ADDR_W*i +: SCCB_ADDR_W];
        sel_data = req_mdata[8*i +: 8];
      end
    end
  end

  // A response accepted together with the command finishes the transaction without visiting RESP.
  always_comb begin
    case (state)
      ST_CMD:  complete = sccb.scmdaccept && (sccb.sresp != SRESP_NULL);
      ST_RESP: complete = (sccb.sresp != SRESP_NULL);
      default: complete = 1'b0;
    endcase
  end

`ifdef SCCB_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign abort = (state != ST_IDLE) && (wd_cnt == TIMEOUT_CYC) && !complete;

  always_ff @(posedge config_clk or negedge config_reset_n) begin
    if (!config_reset_n)               wd_cnt <= '0;
    else if (state == ST_IDLE)         wd_cnt <= '0;
    else if (wd_cnt != TIMEOUT_CYC)    wd_cnt <= wd_cnt + 16'd1;
  end
`else
  assign abort = 1'b0;
`endif

  assign next_ptr = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge config_clk or negedge config_reset_n) begin
    if (!config_reset_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      grant     <= '0;
      mcmd_q    <= MCMD_IDLE;
      maddr_q   <= '0;
      mdata_q   <= '0;
      sdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            mcmd_q    <= sel_cmd;
            maddr_q   <= sel_addr;
            mdata_q   <= sel_data;
            grant     <= win_onehot;
            grant_idx <= win_idx;
            state     <= ST_CMD;
          end
        end
        ST_CMD, ST_RESP: begin
          if (complete || abort) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= next_ptr;
            mcmd_q <= MCMD_IDLE;
            if (complete) sdata_q <= sccb.sdata;
          end else if (state == ST_CMD && sccb.scmdaccept) begin
            mcmd_q <= MCMD_IDLE;
            state  <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_scmdaccept = '0;
    req_sresp      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        req_scmdaccept[i] = (state == ST_CMD) && sccb.scmdaccept;
        if (complete)   req_sresp[2*i +: 2] = sccb.sresp;
        else if (abort) req_sresp[2*i +: 2] = SRESP_ERR;
      end
    end
  end

  assign req_sdata  = complete ? sccb.sdata : sdata_q;
  assign busy       = (state != ST_IDLE);
  assign sccb.mcmd  = mcmd_q;
  assign sccb.maddr = maddr_q;
  assign sccb.mdata = mdata_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed self-checking bench for sccb_arbiter with two requesters; timeout scenario runs when SCCB_ARB_TIMEOUT_EN is defined.
module tb_sccb_arbiter;
  import sccb_arbiter_pkg::*;

  logic        config_clk = 1'b0;
  logic        config_reset_n;
  logic [5:0]  req_mcmd;
  logic [29:0] req_maddr;
  logic [15:0] req_mdata;
  logic [1:0]  req_scmdaccept;
  logic [3:0]  req_sresp;
  logic [7:0]  req_sdata;
  logic [1:0]  grant;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  sccb_arbiter_if sccb ();

  sccb_arbiter #(.NREQ(2), .TIMEOUT_CYC(16'd16)) dut (
    .config_clk     (config_clk),
    .config_reset_n (config_reset_n),
    .req_mcmd       (req_mcmd),
    .req_maddr      (req_maddr),
    .req_mdata      (req_mdata),
    .req_scmdaccept (req_scmdaccept),
    .req_sresp      (req_sresp),
    .req_sdata      (req_sdata),
    .sccb           (sccb),
    .grant          (grant),
    .busy           (busy)
  );

  always #5 config_clk = ~config_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic wait_grant(input int max_cyc);
    for (int n = 0; n < max_cyc && grant == 2'b00; n++) begin
      @(negedge config_clk); #1;
    end
  endtask

  // One transaction with accept and response in separate cycles.
  task automatic serve(input string tag, input logic [1:0] exp_grant, input logic [3:0] exp_resp);
    wait_grant(8);
    check({tag, "_grant"}, grant, exp_grant);
    sccb.scmdaccept = 1'b1; #1;
    check({tag, "_accept"}, req_scmdaccept, exp_grant);
    @(negedge config_clk);
    sccb.scmdaccept = 1'b0;
    sccb.sresp      = SRESP_DVA;
    #1;
    check({tag, "_resp"}, req_sresp, exp_resp);
    @(negedge config_clk);
    sccb.sresp = SRESP_NULL;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL tb_watchdog: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    config_reset_n  = 1'b0;
    req_mcmd        = '0;
    req_maddr       = '0;
    req_mdata       = '0;
    sccb.scmdaccept = 1'b0;
    sccb.sresp      = SRESP_NULL;
    sccb.sdata      = 8'h00;
    #2;
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_mcmd", sccb.mcmd, MCMD_IDLE);
    check("rst_maddr", sccb.maddr, 15'h0);
    check("rst_mdata", sccb.mdata, 8'h00);
    check("rst_req_out", {req_scmdaccept, req_sresp, req_sdata}, 14'h0);
    @(negedge config_clk); config_reset_n = 1'b1;

    // Single write from requester 0
    @(negedge config_clk);
    req_mcmd[2:0]   = MCMD_WR;
    req_maddr[14:0] = 15'h2112;
    req_mdata[7:0]  = 8'h80;
    #1;
    check("t1_mcmd_before", sccb.mcmd, MCMD_IDLE);
    @(negedge config_clk); #1;
    check("t1_mcmd", sccb.mcmd, MCMD_WR);
    check("t1_maddr", sccb.maddr, 15'h2112);
    check("t1_mdata", sccb.mdata, 8'h80);
    check("t1_grant", grant, 2'b01);
    check("t1_busy", busy, 1'b1);
    @(negedge config_clk); #1;
    check("t1_mcmd_hold", sccb.mcmd, MCMD_WR);
    check("t1_no_accept", req_scmdaccept, 2'b00);
    @(negedge config_clk); sccb.scmdaccept = 1'b1; #1;
    check("t1_accept", req_scmdaccept, 2'b01);
    @(negedge config_clk); sccb.scmdaccept = 1'b0; req_mcmd[2:0] = MCMD_IDLE; #1;
    check("t1_mcmd_drop", sccb.mcmd, MCMD_IDLE);
    check("t1_busy_resp", busy, 1'b1);
    @(negedge config_clk); #1;
    check("t1_resp_wait", req_sresp, 4'b0000);
    @(negedge config_clk); sccb.sresp = SRESP_DVA; #1;
    check("t1_resp", req_sresp, 4'b0001);
    check("t1_grant_resp", grant, 2'b01);
    @(negedge config_clk); sccb.sresp = SRESP_NULL; #1;
    check("t1_resp_once", req_sresp, 4'b0000);
    check("t1_grant_idle", grant, 2'b00);
    check("t1_busy_idle", busy, 1'b0);

    // Stray response in IDLE is dropped
    @(negedge config_clk); sccb.sresp = SRESP_DVA; sccb.sdata = 8'h77; #1;
    check("stray_resp", req_sresp, 4'b0000);
    check("stray_sdata", req_sdata, 8'h00);
    check("stray_busy", busy, 1'b0);
    @(negedge config_clk); sccb.sresp = SRESP_NULL; sccb.sdata = 8'h00;

    // Contention from reset: both held, grants alternate 0,1,0,1
    config_reset_n = 1'b0;
    @(negedge config_clk);
    config_reset_n = 1'b1;
    req_mcmd       = {MCMD_WR, MCMD_WR};
    req_maddr      = {15'h4301, 15'h2203};
    req_mdata      = {8'h11, 8'h22};
    #1;
    serve("t2_0", 2'b01, 4'b0001);
    serve("t2_1", 2'b10, 4'b0100);
    serve("t2_2", 2'b01, 4'b0001);
    serve("t2_3", 2'b10, 4'b0100);
    req_mcmd = '0;

    // Read from requester 1 with data
    @(negedge config_clk);
    req_mcmd[5:3]    = MCMD_RD;
    req_maddr[29:15] = 15'h210A;
    #1;
    wait_grant(8);
    check("t3_grant", grant, 2'b10);
    check("t3_mcmd", sccb.mcmd, MCMD_RD);
    check("t3_maddr", sccb.maddr, 15'h210A);
    sccb.scmdaccept = 1'b1; #1;
    check("t3_accept", req_scmdaccept, 2'b10);
    @(negedge config_clk);
    sccb.scmdaccept = 1'b0;
    req_mcmd[5:3]   = MCMD_IDLE;
    sccb.sresp      = SRESP_DVA;
    sccb.sdata      = 8'hA5;
    #1;
    check("t3_resp", req_sresp, 4'b0100);
    check("t3_sdata", req_sdata, 8'hA5);
    @(negedge config_clk); sccb.sresp = SRESP_NULL; sccb.sdata = 8'h00; #1;
    check("t3_sdata_hold", req_sdata, 8'hA5);
    check("t3_grant_idle", grant, 2'b00);

    // Same-cycle accept and response, requester 0 re-requesting immediately
    @(negedge config_clk); req_mcmd[2:0] = MCMD_WR; #1;
    wait_grant(8);
    check("t4_grant", grant, 2'b01);
    sccb.scmdaccept = 1'b1;
    sccb.sresp      = SRESP_DVA;
    sccb.sdata      = 8'h3C;
    #1;
    check("t4_accept", req_scmdaccept, 2'b01);
    check("t4_resp", req_sresp, 4'b0001);
    check("t4_sdata", req_sdata, 8'h3C);
    @(negedge config_clk); sccb.scmdaccept = 1'b0; sccb.sresp = SRESP_NULL; sccb.sdata = 8'h00; #1;
    check("t4_idle_gap_busy", busy, 1'b0);
    check("t4_idle_gap_mcmd", sccb.mcmd, MCMD_IDLE);
    @(negedge config_clk); #1;
    check("t4_reissue_grant", grant, 2'b01);
    check("t4_reissue_mcmd", sccb.mcmd, MCMD_WR);
    sccb.scmdaccept = 1'b1; sccb.sresp = SRESP_DVA; sccb.sdata = 8'h3C; #1;
    @(negedge config_clk);
    sccb.scmdaccept = 1'b0; sccb.sresp = SRESP_NULL; sccb.sdata = 8'h00; req_mcmd = '0; #1;
    check("t4_done", busy, 1'b0);

    // Reset in RESP, then both pending: requester 0 must win
    @(negedge config_clk); req_mcmd[5:3] = MCMD_WR; #1;
    wait_grant(8);
    check("t5_grant", grant, 2'b10);
    sccb.scmdaccept = 1'b1; #1;
    @(negedge config_clk);
    sccb.scmdaccept = 1'b0;
    req_mcmd        = {MCMD_IDLE, MCMD_WR};
    #1;
    check("t5_in_resp", busy, 1'b1);
    config_reset_n = 1'b0;
    sccb.sresp     = SRESP_DVA;
    sccb.sdata     = 8'h99;
    #1;
    check("t5_rst_grant", grant, 2'b00);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_mcmd", sccb.mcmd, MCMD_IDLE);
    check("t5_rst_resp", req_sresp, 4'b0000);
    check("t5_rst_sdata", req_sdata, 8'h00);
    @(negedge config_clk);
    config_reset_n = 1'b1;
    sccb.sresp     = SRESP_NULL;
    sccb.sdata     = 8'h00;
    req_mcmd       = {MCMD_WR, MCMD_WR};
    #1;
    serve("t5_after", 2'b01, 4'b0001);
    req_mcmd = '0;

`ifdef SCCB_ARB_TIMEOUT_EN
    // Downstream never accepts: abort with ERR after TIMEOUT_CYC cycles
    begin
      int n;
      n = 0;
      @(negedge config_clk);
      config_reset_n = 1'b0; #1;
      config_reset_n = 1'b1;
      req_mcmd[2:0]  = MCMD_WR;
      #1;
      wait_grant(8);
      check("t6_grant", grant, 2'b01);
      while (n < 40 && req_sresp != 4'b0011) begin
        @(negedge config_clk); #1;
        n++;
      end
      check("t6_err", req_sresp, 4'b0011);
      check("t6_cycles", n, 16);
      req_mcmd = '0;
      @(negedge config_clk); #1;
      check("t6_mcmd", sccb.mcmd, MCMD_IDLE);
      check("t6_grant_idle", grant, 2'b00);
      sccb.sresp = SRESP_DVA; #1;
      check("t6_late_resp", req_sresp, 4'b0000);
      @(negedge config_clk); sccb.sresp = SRESP_NULL;
    end
`endif

    @(negedge config_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
